vga_sprite_engine: RTL and testbench
====================================

Name: vga_sprite_engine

Overview:
- Pixel-source stage directly upstream of the VGA timing controller.
- Takes the controller's current active-area pixel coordinates and returns the 12-bit RGB444 colour for that pixel in the same cycle: a solid square sprite over a flat background.
- Sprite position and colour live in registers. They update only at the start of vertical blanking, so the picture never tears.
- Optional autonomous bounce motion; host reconfiguration via a valid/ready handshake.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SIZE, 32, sprite edge length in pixels.
- STEP, 2, pixels moved per frame per axis in RUN.
- BG_COLOR, 12'h008, background RGB444.
- FG_COLOR, 12'hFFF, sprite colour after reset.
- X0, 0, sprite x after reset.
- Y0, 0, sprite y after reset.

Ports:
- px_clk  in  1  pixel clock.
- rst  in  1  reset.
- px_h  in  11  current column from the timing controller; 0 outside the active area.
- px_v  in  11  current line from the timing controller; 0 outside the active area.
- cfg_valid  in  1  host config request.
- cfg_ready  out  1  engine can accept a config.
- cfg_x  in  11  requested sprite x.
- cfg_y  in  11  requested sprite y.
- cfg_color  in  12  requested sprite colour.
- cfg_run  in  1  1 = bounce motion, 0 = frozen.
- px_data  out  12  RGB444 for (px_h, px_v).
- frame_tick  out  1  one-cycle pulse, the cycle after the per-frame update.

Behaviour:
- Reset and clock: rst is asynchronous, active-high; px_clk is the clock.
- Reset values:
  - x=X0, y=Y0, dir_x=dir_y=+, state=HOLD, color=FG_COLOR.
  - pending=0, cfg_ready=1, frame_tick=0, pv_q=0.
- Frame tick:
  - pv_q registers px_v every cycle.
  - tick = (pv_q == V_ACTIVE-1) && (px_v == 0), i.e. the first cycle of line V_ACTIVE (start of vertical blanking).
  - Exactly one tick per frame. No other px_v transition generates a tick.
- Handshake:
  - Transfer when cfg_valid && cfg_ready.
  - Captures cfg_x, cfg_y, cfg_color and cfg_run into shadow registers and sets pending.
  - cfg_ready = !pending.
  - A transfer on the tick cycle is not applied on that tick; it waits for the next one.
- At tick, pending=1:
  - x = min(cfg_x, H_ACTIVE-SIZE), y = min(cfg_y, V_ACTIVE-SIZE).
  - color = shadow colour.
  - state = RUN if the shadow run bit is set, else HOLD.
  - pending cleared; directions unchanged.
  - No motion on this tick.
- At tick, pending=0:
  - HOLD: nothing changes.
  - RUN, per axis (x shown; y is the same with V_ACTIVE):
    - dir + and x+STEP >= H_ACTIVE-SIZE: x = H_ACTIVE-SIZE, dir becomes -.
    - dir - and x <= STEP: x = 0, dir becomes +.
    - Otherwise x = x ± STEP.
- Arithmetic:
  - Compare and add at 12 bits so x+SIZE and x+STEP cannot overflow.
  - x and y are always within [0, H_ACTIVE-SIZE] and [0, V_ACTIVE-SIZE].
- px_data:
  - Combinational, zero latency, because the controller samples it the same cycle.
  - Equals color when x <= px_h < x+SIZE and y <= px_v < y+SIZE; otherwise BG_COLOR.
  - In blanking, px_h/px_v read 0, so px_data may show the sprite or background; the controller blanks it.
- frame_tick: registered copy of tick; high for exactly one px_clk cycle per frame.
- Reset mid-operation: all state returns to reset values immediately. An in-flight pending config is discarded.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE timing constants shared with the controller.
  - 11-bit coordinate type.
  - 12-bit RGB444 colour type.
  - State encoding HOLD/RUN.
- One natural sub-module, sprite_axis: a single-axis position/direction register with bounce and clamp-load, instantiated twice with LIMIT = H_ACTIVE-SIZE and V_ACTIVE-SIZE.

Test Plan:
- Reset, then drive px_h=0, px_v=0 -> px_data=12'hFFF; px_h=32 -> 12'h008; cfg_ready=1; frame_tick=0.
- Step px_v from 479 to 0 -> frame_tick pulses exactly one cycle later. Hold px_v at 0 for 40 lines -> no further pulses.
- Config cfg_x=100, cfg_y=50, cfg_color=12'hF00, cfg_run=0:
  - cfg_ready drops to 0 the cycle after acceptance.
  - Before the next tick, px_data at (100,50) is still background.
  - After the tick, (100,50) and (131,81) -> 12'hF00; (132,50) -> 12'h008; cfg_ready returns to 1.
- Config cfg_x=700, cfg_y=470 -> clamped to x=608, y=448.
- Config x=604, run=1:
  - tick1: x=606.
  - tick2: x=608, dir becomes -.
  - tick3: x=606.
  - Check bounce at 0 symmetrically starting from x=2.
- cfg_valid asserted on the exact tick cycle -> values applied on the following tick, not the current one.
- Assert rst mid-RUN with pending=1 -> x=X0, y=Y0, HOLD, pending cleared asynchronously.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Definitions shared by the VGA timing controller and the pixel sources.
//   VGA_H_ACTIVE / VGA_V_ACTIVE : visible pixels per line / lines per frame
//   coord_t  : 11-bit pixel coordinate, as produced by the timing controller
//   calc_t   : 12-bit working width for coordinate arithmetic (x+SIZE and
//              x+STEP must not wrap)
//   rgb_t    : 12-bit RGB444 colour
//   motion_t : sprite motion mode, HOLD (frozen) or RUN (bouncing)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    localparam int COORD_W = 11;
    localparam int CALC_W  = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CALC_W-1:0]  calc_t;
    typedef logic [11:0]        rgb_t;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } motion_t;

endpackage

// File: rtl/sprite_axis.sv
// ---------------------------------------------------------------------------
// sprite_axis
// One axis of the sprite position: a position register plus a direction
// flag.  A load stores the requested position clamped to [0, LIMIT] and
// leaves the direction alone.  A move advances by STEP in the current
// direction and bounces off 0 and LIMIT, landing exactly on the wall.
// The two axes are identical apart from LIMIT and the reset position.
//
// Ports
//   px_clk     in   pixel clock
//   rst        in   asynchronous active-high reset
//   i_load     in   load clamped i_load_pos this cycle (takes priority)
//   i_load_pos in   requested position
//   i_move     in   take one bounce step this cycle
//   o_pos      out  current position, always within [0, LIMIT]
// ---------------------------------------------------------------------------
module sprite_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 608,
    parameter int STEP  = 2,
    parameter int INIT  = 0
)(
    input  logic   px_clk,
    input  logic   rst,
    input  logic   i_load,
    input  coord_t i_load_pos,
    input  logic   i_move,
    output coord_t o_pos
);

    localparam calc_t  LIMIT_C = calc_t'(LIMIT);
    localparam calc_t  STEP_C  = calc_t'(STEP);
    localparam coord_t LIMIT_P = coord_t'(LIMIT);
    localparam coord_t INIT_P  = coord_t'(INIT);

    coord_t r_pos;
    logic   r_dir_neg;      // 0 = moving towards LIMIT, 1 = towards 0

    calc_t  w_pos_ext;
    calc_t  w_req_ext;
    calc_t  w_clamp;
    calc_t  w_fwd;
    calc_t  w_back;

    // Everything is evaluated one bit wider than a coordinate so that an
    // out-of-range request or a step past the wall cannot wrap around.
    assign w_pos_ext = {1'b0, r_pos};
    assign w_req_ext = {1'b0, i_load_pos};
    assign w_clamp   = (w_req_ext > LIMIT_C) ? LIMIT_C : w_req_ext;
    assign w_fwd     = w_pos_ext + STEP_C;
    assign w_back    = w_pos_ext - STEP_C;

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_pos     <= INIT_P;
            r_dir_neg <= 1'b0;
        end else if (i_load) begin
            r_pos <= coord_t'(w_clamp);
        end else if (i_move) begin
            if (!r_dir_neg) begin
                if (w_fwd >= LIMIT_C) begin
                    r_pos     <= LIMIT_P;
                    r_dir_neg <= 1'b1;
                end else begin
                    r_pos <= coord_t'(w_fwd);
                end
            end else begin
                if (w_pos_ext <= STEP_C) begin
                    r_pos     <= '0;
                    r_dir_neg <= 1'b0;
                end else begin
                    r_pos <= coord_t'(w_back);
                end
            end
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// vga_sprite_engine
// Pixel source sitting just upstream of the VGA timing controller.  For the
// controller's current active-area coordinate it returns, in the same
// cycle, the colour of a solid SIZE x SIZE sprite drawn over a flat
// background.  Sprite position, colour and motion mode only change on the
// frame tick (first cycle of vertical blanking), so a frame is never drawn
// with a half-updated sprite.  A host queues a new configuration through a
// one-deep valid/ready shadow register; it is applied on the next tick.
//
// Ports
//   px_clk      in   pixel clock
//   rst         in   asynchronous active-high reset
//   px_h, px_v  in   current active column / line (0 outside active area)
//   cfg_valid   in   host offers a configuration
//   cfg_ready   out  shadow register free; high means a config is accepted
//   cfg_x/y     in   requested sprite position (clamped on apply)
//   cfg_color   in   requested sprite colour
//   cfg_run     in   1 = bounce, 0 = frozen
//   px_data     out  RGB444 for (px_h, px_v), combinational
//   frame_tick  out  one-cycle pulse the cycle after the per-frame update
// ---------------------------------------------------------------------------
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   SIZE     = 32,
    parameter int   STEP     = 2,
    parameter rgb_t BG_COLOR = 12'h008,
    parameter rgb_t FG_COLOR = 12'hFFF,
    parameter int   X0       = 0,
    parameter int   Y0       = 0
)(
    input  logic   px_clk,
    input  logic   rst,
    input  coord_t px_h,
    input  coord_t px_v,
    input  logic   cfg_valid,
    output logic   cfg_ready,
    input  coord_t cfg_x,
    input  coord_t cfg_y,
    input  rgb_t   cfg_color,
    input  logic   cfg_run,
    output rgb_t   px_data,
    output logic   frame_tick
);

    localparam coord_t LAST_LINE = coord_t'(V_ACTIVE - 1);
    localparam calc_t  SIZE_C    = calc_t'(SIZE);

    // Per-axis tables: index 0 is x, index 1 is y.
    localparam int AXIS_LIMIT [2] = '{H_ACTIVE - SIZE, V_ACTIVE - SIZE};
    localparam int AXIS_INIT  [2] = '{X0, Y0};

    coord_t  r_pv_q;
    logic    r_pending;
    coord_t  r_sh_pos [2];
    rgb_t    r_sh_color;
    logic    r_sh_run;
    motion_t r_state;
    rgb_t    r_color;
    logic    r_frame_tick;

    logic    w_tick;
    logic    w_xfer;
    logic    w_load;
    logic    w_move;
    coord_t  w_pos  [2];
    coord_t  w_req  [2];
    coord_t  w_px   [2];
    logic    w_hit  [2];

    // The only way px_v goes from the last active line to 0 is entering
    // vertical blanking, so this fires exactly once per frame.
    assign w_tick    = (r_pv_q == LAST_LINE) && (px_v == '0);
    assign cfg_ready = !r_pending;
    assign w_xfer    = cfg_valid && !r_pending;

    // A queued config pre-empts motion for that frame.
    assign w_load = w_tick && r_pending;
    assign w_move = w_tick && !r_pending && (r_state == ST_RUN);

    assign w_req[0] = r_sh_pos[0];
    assign w_req[1] = r_sh_pos[1];
    assign w_px[0]  = px_h;
    assign w_px[1]  = px_v;

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_pv_q       <= '0;
            r_pending    <= 1'b0;
            r_sh_pos[0]  <= '0;
            r_sh_pos[1]  <= '0;
            r_sh_color   <= '0;
            r_sh_run     <= 1'b0;
            r_state      <= ST_HOLD;
            r_color      <= FG_COLOR;
            r_frame_tick <= 1'b0;
        end else begin
            r_pv_q       <= px_v;
            r_frame_tick <= w_tick;
            if (w_load) begin
                r_pending <= 1'b0;
                r_color   <= r_sh_color;
                r_state   <= r_sh_run ? ST_RUN : ST_HOLD;
            end else if (w_xfer) begin
                // A transfer on a tick cycle lands here with pending still
                // low, so it is held until the following tick.
                r_pending   <= 1'b1;
                r_sh_pos[0] <= cfg_x;
                r_sh_pos[1] <= cfg_y;
                r_sh_color  <= cfg_color;
                r_sh_run    <= cfg_run;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_axis
            calc_t w_lo;
            calc_t w_cur;

            sprite_axis #(
                .LIMIT (AXIS_LIMIT[gi]),
                .STEP  (STEP),
                .INIT  (AXIS_INIT[gi])
            ) u_axis (
                .px_clk     (px_clk),
                .rst        (rst),
                .i_load     (w_load),
                .i_load_pos (w_req[gi]),
                .i_move     (w_move),
                .o_pos      (w_pos[gi])
            );

            // Widened so that pos+SIZE near the right/bottom edge is exact.
            assign w_lo     = {1'b0, w_pos[gi]};
            assign w_cur    = {1'b0, w_px[gi]};
            assign w_hit[gi] = (w_cur >= w_lo) && (w_cur < (w_lo + SIZE_C));
        end
    endgenerate

    // Zero latency: the controller samples this in the same cycle.
    assign px_data    = (w_hit[0] && w_hit[1]) ? r_color : BG_COLOR;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_engine
// Directed steps followed by a randomised section, all in one initial
// block.  A frame-level model of the sprite (position, direction, colour,
// mode and one queued config) predicts frame_tick, cfg_ready and px_data.
// ---------------------------------------------------------------------------
module tb_vga_sprite_engine;

    localparam int HA   = 640;
    localparam int VA   = 480;
    localparam int SZ   = 32;
    localparam int STP  = 2;
    localparam int BG   = 'h008;
    localparam int FG   = 'hFFF;
    localparam int XLIM = HA - SZ;
    localparam int YLIM = VA - SZ;

    logic        px_clk = 1'b0;
    logic        rst;
    logic [10:0] px_h;
    logic [10:0] px_v;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [10:0] cfg_x;
    logic [10:0] cfg_y;
    logic [11:0] cfg_color;
    logic        cfg_run;
    logic [11:0] px_data;
    logic        frame_tick;

    always #5 px_clk = ~px_clk;

    vga_sprite_engine dut (
        .px_clk     (px_clk),
        .rst        (rst),
        .px_h       (px_h),
        .px_v       (px_v),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_color  (cfg_color),
        .cfg_run    (cfg_run),
        .px_data    (px_data),
        .frame_tick (frame_tick)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_x, m_y, m_dx, m_dy, m_run, m_color;
    int m_pending, m_sx, m_sy, m_scolor, m_srun;
    int m_pvq, m_tick;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
        m_run = 0; m_color = FG;
        m_pending = 0; m_sx = 0; m_sy = 0; m_scolor = 0; m_srun = 0;
        m_pvq = 0; m_tick = 0;
    endtask

    function automatic int exp_px(int h, int v);
        if (h >= m_x && h < m_x + SZ && v >= m_y && v < m_y + SZ)
            return m_color;
        return BG;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic move_axis(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + STP >= lim) begin p = lim; d = -1; end
            else p = p + STP;
        end else begin
            if (p <= STP) begin p = 0; d = 1; end
            else p = p - STP;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total = n_total + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clock cycle with the inputs currently driven; model follows it.
    task automatic step();
        int t, xf;
        t  = (m_pvq == VA - 1 && px_v == 0) ? 1 : 0;
        xf = (cfg_valid && m_pending == 0) ? 1 : 0;
        @(posedge px_clk);
        #1;
        if (t != 0) begin
            if (m_pending != 0) begin
                m_x = imin(m_sx, XLIM);
                m_y = imin(m_sy, YLIM);
                m_color = m_scolor;
                m_run = m_srun;
                m_pending = 0;
            end else if (m_run != 0) begin
                move_axis(m_x, m_dx, XLIM);
                move_axis(m_y, m_dy, YLIM);
            end
        end
        if (xf != 0) begin
            m_sx = cfg_x; m_sy = cfg_y; m_scolor = cfg_color; m_srun = cfg_run;
            m_pending = 1;
        end
        m_pvq = px_v;
        m_tick = t;
        check("frame_tick", {31'b0, frame_tick}, m_tick);
        check("cfg_ready", {31'b0, cfg_ready}, (m_pending == 0) ? 1 : 0);
    endtask

    // Combinational probe inside the current cycle; inputs restored after.
    task automatic probe(input string tag, input int h, input int v);
        logic [10:0] sh, sv;
        sh = px_h; sv = px_v;
        px_h = 11'(h); px_v = 11'(v);
        #1;
        check(tag, {20'b0, px_data}, exp_px(h, v));
        px_h = sh; px_v = sv;
    endtask

    task automatic corners();
        probe("px_tl", m_x, m_y);
        probe("px_br", m_x + SZ - 1, m_y + SZ - 1);
        probe("px_right", m_x + SZ, m_y);
        if (m_x > 0) probe("px_left", m_x - 1, m_y);
        else         probe("px_below", m_x, m_y + SZ);
        step();
    endtask

    task automatic frame();
        px_v = 11'(VA - 1); step();
        px_v = 11'd0;       step();
        px_v = 11'd100;     step();
    endtask

    task automatic send_cfg(input int x, input int y, input int c, input int r);
        cfg_valid = 1'b1;
        cfg_x = 11'(x); cfg_y = 11'(y); cfg_color = 12'(c); cfg_run = r[0];
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; px_h = '0; px_v = '0;
        cfg_valid = 1'b0; cfg_x = '0; cfg_y = '0; cfg_color = '0; cfg_run = 1'b0;
        model_reset();
        repeat (2) @(posedge px_clk);
        #1;
        rst = 1'b0;

        // Reset state
        probe("rst_px_origin", 0, 0);
        probe("rst_px_32", 32, 0);
        check("rst_cfg_ready", {31'b0, cfg_ready}, 1);
        check("rst_frame_tick", {31'b0, frame_tick}, 0);
        step();

        // One tick per frame; holding px_v at 0 gives no further pulses
        frame();
        px_v = 11'd0;
        repeat (40) step();
        px_v = 11'd100;
        step();

        // Config (100,50) red, frozen
        send_cfg(100, 50, 'hF00, 0);
        probe("pre_tick_bg", 100, 50);
        step();
        frame();
        probe("cfg_tl", 100, 50);
        probe("cfg_br", 131, 81);
        probe("cfg_right", 132, 50);
        step();

        // Clamp
        send_cfg(700, 470, 'h0F0, 0);
        frame();
        corners();
        probe("clamp_corner", 639, 479);
        step();

        // Right wall bounce from 604
        send_cfg(604, 10, 'h00F, 1);
        frame();
        for (int i = 0; i < 3; i++) begin
            frame();
            corners();
        end

        // Left wall bounce from 2 (x direction is now towards 0)
        send_cfg(2, 200, 'hABC, 1);
        frame();
        for (int i = 0; i < 3; i++) begin
            frame();
            corners();
        end

        // Transfer on the tick cycle itself
        send_cfg(300, 300, 'h123, 0);
        frame();
        px_v = 11'(VA - 1); step();
        px_v = 11'd0;
        cfg_valid = 1'b1; cfg_x = 11'd50; cfg_y = 11'd60; cfg_color = 12'h456; cfg_run = 1'b0;
        step();
        cfg_valid = 1'b0; px_v = 11'd100;
        step();
        corners();
        frame();
        corners();

        // Randomised section, including near-miss px_v transitions
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: send_cfg(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                            int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)));
                1: frame();
                2: begin
                    px_v = 11'(VA - 2); step();
                    px_v = 11'd0;       step();
                    px_v = 11'(VA - 1); step();
                    px_v = 11'd1;       step();
                    px_v = 11'd100;     step();
                end
                default: begin
                    probe("rnd_px", int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)));
                    probe("rnd_px", int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)));
                    step();
                end
            endcase
            corners();
        end

        // Asynchronous reset while running with a config queued
        send_cfg(200, 100, 'h0FF, 1);
        frame();
        frame();
        send_cfg(400, 400, 'hF0F, 0);
        @(posedge px_clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_cfg_ready", {31'b0, cfg_ready}, 1);
        check("arst_frame_tick", {31'b0, frame_tick}, 0);
        probe("arst_origin", 0, 0);
        probe("arst_200", 200, 100);
        #1;
        rst = 1'b0;
        px_v = 11'd100;
        step();
        frame();
        frame();
        corners();
        probe("arst_no_apply", 400, 400);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
